// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer blocks.
//   nn_state_t : neuron MAC FSM states (accumulate, finalize, output hold)
//   DEF_*      : default activation/weight widths and fixed-point fraction
//   relu_sat   : ReLU followed by clamp to the largest positive DW-bit value
package nn_pkg;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_FIN = 2'd1,
        ST_OUT = 2'd2
    } nn_state_t;

    localparam int DEF_DW   = 8;
    localparam int DEF_WW   = 8;
    localparam int DEF_FRAC = 4;

    // Negative values become 0; values above 2^(dw-1)-1 clamp to that limit.
    function automatic logic signed [63:0] relu_sat(input logic signed [63:0] r,
                                                    input int dw);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (dw - 1)) - 64'sd1;
        if (r < 64'sd0)
            return '0;
        else if (r > lim)
            return lim;
        else
            return r;
    endfunction

endpackage

// File: rtl/neuron_mac_weight_rf.sv
// Weight/bias register file for one neuron.
//   N_IN+1 entries of WW bits: entries 0..N_IN-1 are weights, entry N_IN is bias.
//   i_clk            : clock
//   i_we/i_addr/i_data : synchronous write port
//   i_rd_addr        : asynchronous read address, o_rd_data its contents
//   o_bias           : bias entry, always visible
// No reset: contents are undefined until written. A write and a read of the
// same entry in one cycle returns the old value, since the read is from the
// register before the edge.
module neuron_mac_weight_rf #(
    parameter int N_IN = 4,
    parameter int WW   = 8
) (
    input  logic                         i_clk,
    input  logic                         i_we,
    input  logic [$clog2(N_IN+1)-1:0]    i_addr,
    input  logic signed [WW-1:0]         i_data,
    input  logic [$clog2(N_IN+1)-1:0]    i_rd_addr,
    output logic signed [WW-1:0]         o_rd_data,
    output logic signed [WW-1:0]         o_bias
);

    localparam int AW = $clog2(N_IN + 1);
    localparam logic [AW-1:0] LAST = AW'(N_IN);

    logic signed [WW-1:0] r_mem [N_IN+1];

    always_ff @(posedge i_clk) begin
        if (i_we && (i_addr <= LAST))
            r_mem[i_addr] <= i_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];
    assign o_bias    = r_mem[N_IN];

endmodule

// File: rtl/layer_hidden_neuron_mac.sv
// Hidden-layer neuron: multiply-accumulate of N_IN activations with stored
// weights, bias add, fixed-point rescale and ReLU with saturation.
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid/in_x/in_ready     : activation beat handshake
//   ack_mac                    : pulse marking the end of the current sum
//   w_we/w_addr/w_data         : weight (0..N_IN-1) / bias (N_IN) write
//   out_valid/out_data/out_ready : result handshake
//   err                        : sticky, more than N_IN beats in one sum
module layer_hidden_neuron_mac
    import nn_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int DW   = DEF_DW,
    parameter int WW   = DEF_WW,
    parameter int FRAC = DEF_FRAC,
    parameter int ACCW = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DW-1:0]         in_x,
    output logic                         in_ready,
    input  logic                         ack_mac,
    input  logic                         w_we,
    input  logic [$clog2(N_IN+1)-1:0]    w_addr,
    input  logic signed [WW-1:0]         w_data,
    output logic                         out_valid,
    output logic signed [DW-1:0]         out_data,
    input  logic                         out_ready,
    output logic                         err
);

    localparam int AW = $clog2(N_IN + 1);
    localparam int PW = DW + WW;
    localparam logic [AW-1:0] IDX_FULL = AW'(N_IN);
    localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

    nn_state_t              r_state;
    logic signed [ACCW-1:0] r_acc;
    logic [AW-1:0]          r_idx;
    logic                   r_out_valid;
    logic signed [DW-1:0]   r_out_data;
    logic                   r_err;

    logic signed [WW-1:0]   w_weight;
    logic signed [WW-1:0]   w_bias;
    logic signed [PW-1:0]   w_prod;
    logic signed [ACCW:0]   w_sum;
    logic signed [ACCW-1:0] w_acc_next;
    logic signed [ACCW+1:0] w_bias_ext;
    logic signed [ACCW+1:0] w_fin;
    logic signed [ACCW+1:0] w_r;
    logic signed [63:0]     w_r64;

    neuron_mac_weight_rf #(
        .N_IN (N_IN),
        .WW   (WW)
    ) u_wrf (
        .i_clk     (clk),
        .i_we      (w_we),
        .i_addr    (w_addr),
        .i_data    (w_data),
        .i_rd_addr (r_idx),
        .o_rd_data (w_weight),
        .o_bias    (w_bias)
    );

    assign w_prod = in_x * w_weight;
    assign w_sum  = (ACCW+1)'(r_acc) + (ACCW+1)'(w_prod);

    // One extra bit of headroom: a top-two-bit disagreement means overflow.
    always_comb begin
        w_acc_next = w_sum[ACCW-1:0];
        if (w_sum[ACCW] != w_sum[ACCW-1])
            w_acc_next = w_sum[ACCW] ? ACC_MIN : ACC_MAX;
    end

    // Bias is aligned to the product scale (2*FRAC) before the sum is
    // shifted back down to FRAC fractional bits; >>> floors.
    assign w_bias_ext = (ACCW+2)'(w_bias);
    assign w_fin      = (ACCW+2)'(r_acc) + (w_bias_ext <<< FRAC);
    assign w_r        = w_fin >>> FRAC;
    assign w_r64      = 64'(w_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_acc       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (in_valid) begin
                        if (r_idx == IDX_FULL) begin
                            r_err <= 1'b1;
                        end else begin
                            r_acc <= w_acc_next;
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                    if (ack_mac)
                        r_state <= ST_FIN;
                end
                ST_FIN: begin
                    r_out_data  <= DW'(relu_sat(w_r64, DW));
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_idx       <= '0;
                        r_state     <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACC);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err       = r_err;

endmodule

// File: tb/tb_layer_hidden_neuron_mac.sv
// Directed bench for layer_hidden_neuron_mac (N_IN=4, DW=WW=8, FRAC=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_layer_hidden_neuron_mac;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic signed [7:0] in_x;
    logic              in_ready;
    logic              ack_mac;
    logic              w_we;
    logic [2:0]        w_addr;
    logic signed [7:0] w_data;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic              out_ready;
    logic              err;

    int n_total;
    int n_bad;

    layer_hidden_neuron_mac #(
        .N_IN (4),
        .DW   (8),
        .WW   (8),
        .FRAC (4),
        .ACCW (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_ready  (in_ready),
        .ack_mac   (ack_mac),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_weights(input logic signed [7:0] w, input logic signed [7:0] b);
        for (int i = 0; i < 5; i++) begin
            w_we   = 1'b1;
            w_addr = 3'(i);
            w_data = (i == 4) ? b : w;
            tick();
        end
        w_we = 1'b0;
    endtask

    // n beats of constant x; ack_mac rides with the last beat when ack is set.
    task automatic do_beats(input int n, input logic signed [7:0] x, input logic ack);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_x     = x;
            ack_mac  = ack && (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        ack_mac  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (out_valid) break;
            tick();
        end
        check(tag, int'(out_valid), 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        ack_mac   = 1'b0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        out_ready = 1'b0;

        do_reset();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_err", int'(err), 0);

        // 4 x (1.0 * 1.0) = 4.0 -> 64, valid exactly two cycles after ack
        set_weights(8'sd16, 8'sd0);
        do_beats(4, 8'sd16, 1'b1);
        check("lat_fin_not_valid", int'(out_valid), 0);
        tick();
        check("lat_valid_t2", int'(out_valid), 1);
        check("basic_64", int'(out_data), 64);
        consume();
        check("basic_back_acc", int'(in_ready), 1);
        check("basic_valid_clr", int'(out_valid), 0);

        // ReLU of -4.0
        set_weights(-8'sd16, 8'sd0);
        do_beats(4, 8'sd16, 1'b1);
        wait_out("relu_wait");
        check("relu_0", int'(out_data), 0);
        consume();

        // 4*16129 + 127*16 = 66548 -> 4159, clamps to 127
        set_weights(8'sd127, 8'sd127);
        do_beats(4, 8'sd127, 1'b1);
        wait_out("sat_wait");
        check("sat_127", int'(out_data), 127);
        consume();

        // bias 1.0: (1024 + 256) >>> 4 = 80
        set_weights(8'sd16, 8'sd16);
        do_beats(4, 8'sd16, 1'b1);
        wait_out("bias_wait");
        check("bias_80", int'(out_data), 80);
        consume();

        // floor: 4 * (3 * 1) = 12 -> 12 >>> 4 = 0; x=20 -> 80 >>> 4 = 5
        set_weights(8'sd1, 8'sd0);
        do_beats(4, 8'sd20, 1'b1);
        wait_out("floor_wait");
        check("floor_5", int'(out_data), 5);
        consume();

        // Same-cycle write to weight 0 while beat 0 reads it: old 16 is used
        set_weights(8'sd16, 8'sd0);
        in_valid = 1'b1;
        in_x     = 8'sd16;
        w_we     = 1'b1;
        w_addr   = 3'd0;
        w_data   = 8'sd0;
        tick();
        w_we = 1'b0;
        do_beats(3, 8'sd16, 1'b1);
        wait_out("rdw_wait");
        check("rdw_old_64", int'(out_data), 64);
        consume();
        set_weights(8'sd16, 8'sd0);

        // Hold in OUT for 5 cycles with beats and ack_mac applied; 4*128 -> 32
        do_beats(4, 8'sd8, 1'b1);
        wait_out("hold_wait");
        in_valid = 1'b1;
        in_x     = 8'sd16;
        ack_mac  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), 32);
            check("hold_in_ready", int'(in_ready), 0);
        end
        ack_mac = 1'b0;
        consume();
        in_valid = 1'b0;
        check("hold_rel_in_ready", int'(in_ready), 1);
        check("hold_rel_valid", int'(out_valid), 0);
        do_beats(4, 8'sd16, 1'b1);
        wait_out("acc_clr_wait");
        check("acc_clr_64", int'(out_data), 64);
        consume();

        // Fifth beat discarded, err sticky across the next sum until rst
        check("err_pre", int'(err), 0);
        do_beats(5, 8'sd16, 1'b1);
        wait_out("ovf_wait");
        check("ovf_64", int'(out_data), 64);
        check("ovf_err", int'(err), 1);
        consume();
        do_beats(4, 8'sd8, 1'b1);
        wait_out("ovf_next_wait");
        check("ovf_next_32", int'(out_data), 32);
        check("ovf_err_sticky", int'(err), 1);
        consume();
        do_reset();
        check("err_rst_clr", int'(err), 0);

        // rst mid-sum abandons it; weights survive reset
        do_beats(2, 8'sd16, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_valid", int'(out_valid), 0);
        end
        do_beats(4, 8'sd16, 1'b1);
        wait_out("midrst_wait");
        check("midrst_64", int'(out_data), 64);
        consume();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/layer_hidden_neuron_mac.md
LAYER_HIDDEN_NEURON_MAC -- requirements
Module: layer_hidden_neuron_mac

Interface
REQ-001 Parameter N_IN, 4, number of inputs (weights) per neuron; SHALL be >= 2.
REQ-002 Parameter DW, 8, signed width of input activations and output.
REQ-003 Parameter WW, 8, signed width of weights and bias.
REQ-004 Parameter FRAC, 4, fractional bits of the fixed-point format (shared by x, w, bias, out).
REQ-005 Parameter ACCW, 24, signed accumulator width; SHALL be >= DW+WW+clog2(N_IN)+1.
REQ-006 clk  in  1  clock; all logic on posedge clk.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 in_valid  in  1  input activation beat present.
REQ-009 in_x  in  DW  signed activation.
REQ-010 in_ready  out  1  block accepts a beat this cycle.
REQ-011 ack_mac  in  1  one-cycle pulse from the layer counter: the current sum is complete, finalize.
REQ-012 w_we  in  1  weight/bias write strobe.
REQ-013 w_addr  in  clog2(N_IN+1)  0..N_IN-1 select a weight; N_IN selects bias.
REQ-014 w_data  in  WW  signed weight/bias value.
REQ-015 out_valid  out  1  result held valid.
REQ-016 out_data  out  DW  signed post-ReLU neuron output.
REQ-017 out_ready  in  1  downstream consumes result.
REQ-018 err  out  1  sticky: more than N_IN beats seen in one sum.

Function
REQ-019 FSM states SHALL be ACC, FIN, OUT; ACC after reset.
REQ-020 in_ready SHALL be 1 exactly in ACC; a beat is accepted when in_valid && in_ready.
REQ-021 On an accepted beat, acc <= acc + in_x*w[idx] (full-precision signed product, sign-extended), idx <= idx+1.
REQ-022 Accumulation into acc SHALL saturate at the ACCW signed limits, never wrap.
REQ-023 A beat accepted when idx == N_IN SHALL be discarded and set err; idx SHALL not exceed N_IN.
REQ-024 ack_mac in ACC SHALL move to FIN next cycle; a beat accepted in the same cycle SHALL be included in the sum.
REQ-025 ack_mac outside ACC SHALL be ignored.
REQ-026 FIN (exactly one cycle): r = (acc + (bias <<< FRAC)) >>> FRAC (arithmetic shift, floor); out_data <= 0 if r < 0, 2^(DW-1)-1 if r exceeds it, else r; out_valid <= 1; state -> OUT.
REQ-027 OUT: hold out_data/out_valid stable until out_ready; on out_valid && out_ready clear out_valid, acc, idx and return to ACC next cycle.
REQ-028 Latency: ack_mac at cycle t -> out_valid high at t+2.
REQ-029 Weight writes SHALL be accepted in any state; a write to the entry read in the same cycle SHALL return the old value to the MAC.
REQ-030 err SHALL be cleared only by rst.

Reset
REQ-031 rst SHALL set state ACC, acc 0, idx 0, out_valid 0, out_data 0, err 0, in_ready 1 after the reset edge.
REQ-032 rst SHALL NOT clear weights or bias (unknown until written); rst mid-sum SHALL abandon the sum with no output.

Structure
REQ-033 Shared package nn_pkg SHALL hold the FSM state typedef, default DW/WW/FRAC, and the saturation/ReLU function.
REQ-034 Weight/bias storage SHALL be the sub-module neuron_mac_weight_rf (N_IN+1 x WW, 1 write port, 1 async read port plus bias read).

Verification (N_IN=4, DW=WW=8, FRAC=4)
REQ-035 Weights all 16, bias 0, four beats x=16, ack_mac with 4th beat -> out_data 64, out_valid 2 cycles after ack_mac.
REQ-036 Weights all -16, x=16 x4, bias 0 -> out_data 0 (ReLU).
REQ-037 Weights 127, x 127 x4, bias 127 -> out_data 127 (saturation, no wrap).
REQ-038 out_ready held 0 for 5 cycles in OUT -> out_data/out_valid stable, in_ready 0, in_valid beats ignored; then out_ready 1 -> ACC next cycle with acc 0.
REQ-039 Five beats before ack_mac -> err 1, result equals four-beat sum; err persists through next sum until rst.
REQ-040 rst asserted after 2 beats -> no out_valid, next sum with four beats x=16, weights 16 -> 64.
